// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmit scheduler.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP_ST
    } state_e;

    localparam logic IORW_READ  = 1'b1;
    localparam logic IORW_WRITE = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [IDX_W-1:0]   grant_c,
    output logic               grant_valid_c
);

    // Index reached by stepping `step` places past `base`, wrapped into 0..NUM_REQ-1.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan farthest-first so the nearest requester after ptr wins.
    always_comb begin
        grant_c       = '0;
        grant_valid_c = 1'b0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (en && req[rot_idx(ptr, k)]) begin
                grant_c       = rot_idx(ptr, k);
                grant_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spart_tx_sched.sv
// Round-robin sharing of one SPART transmitter among NUM_REQ byte producers,
// plus edge-triggered capture of received bytes.
module spart_tx_sched
    import spart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned GAP     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic                 err,
    output logic                 iorw,
    output logic [7:0]           databus,
    input  logic                 tbr,
    input  logic                 rda,
    input  logic [7:0]           rx_buffer,
    output logic [7:0]           rx_data,
    output logic                 rx_valid
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    state_e             state;
    state_e             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   gap_d;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   tmo_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               busy_d;
    logic               err_d;
    logic               iorw_d;
    logic [7:0]         databus_d;
    logic               rda_q;

    logic               arb_en_c;
    logic [IDX_W-1:0]   grant_c;
    logic               grant_valid_c;

    // A launch is only offered once the SPART is ready and iorw has rested long enough.
    assign arb_en_c = (state == IDLE) && tbr && (gap_cnt == '0);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req           (req),
        .ptr           (ptr),
        .en            (arb_en_c),
        .grant_c       (grant_c),
        .grant_valid_c (grant_valid_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_valid_c) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tbr) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = GAP_ST;
                end
            end
            WAIT_DONE: begin
                if (tbr) begin
                    state_nxt = GAP_ST;
                end
            end
            GAP_ST: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs and counters.
    always_comb begin
        ack_d     = '0;
        err_d     = 1'b0;
        iorw_d    = IORW_READ;
        databus_d = databus;
        ptr_d     = ptr;
        tmo_d     = tmo_cnt;
        gap_d     = (gap_cnt != '0) ? gap_cnt - CNT_W'(1) : gap_cnt;
        busy_d    = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid_c) begin
                    ack_d[grant_c] = 1'b1;
                    databus_d      = req_data[{grant_c, 3'b000} +: 8];
                    ptr_d          = grant_c;
                end
            end
            LAUNCH: begin
                iorw_d = IORW_WRITE;
                tmo_d  = '0;
            end
            WAIT_BUSY: begin
                tmo_d = tmo_cnt + CNT_W'(1);
                if (tbr && (tmo_cnt == TMO_LAST)) begin
                    err_d = 1'b1;
                end
            end
            GAP_ST: begin
                gap_d = GAP_LOAD;
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers; reset forces iorw back to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= PTR_INIT;
            gap_cnt <= GAP_INIT;
            tmo_cnt <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
            iorw    <= IORW_READ;
            databus <= '0;
        end else begin
            ptr     <= ptr_d;
            gap_cnt <= gap_d;
            tmo_cnt <= tmo_d;
            ack     <= ack_d;
            busy    <= busy_d;
            err     <= err_d;
            iorw    <= iorw_d;
            databus <= databus_d;
        end
    end

    // Receive capture on the rising edge of rda, independent of the transmit FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda_q    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rda_q    <= rda;
            rx_valid <= rda & ~rda_q;
            if (rda && !rda_q) begin
                rx_data <= rx_buffer;
            end
        end
    end

endmodule

// File: tb/tb_spart_tx_sched.sv
// Directed bench for spart_tx_sched with a simple SPART transmitter model.
`timescale 1ns/1ps
module tb_spart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic                 err;
    logic                 iorw;
    logic [7:0]           databus;
    logic                 tbr;
    logic                 rda = 1'b0;
    logic [7:0]           rx_buffer = '0;
    logic [7:0]           rx_data;
    logic                 rx_valid;

    int pass_cnt = 0;
    int total    = 0;

    spart_tx_sched #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .busy      (busy),
        .err       (err),
        .iorw      (iorw),
        .databus   (databus),
        .tbr       (tbr),
        .rda       (rda),
        .rx_buffer (rx_buffer),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid)
    );

    always #5 clk = ~clk;

    // SPART transmitter model: a low iorw launches a start+8 data+stop frame, one bit per cycle.
    logic       tbr_stuck = 1'b0;
    logic [9:0] frame;
    logic [9:0] bits;
    logic [9:0] last_frame;
    int         sh_cnt;
    logic [7:0] sent_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbr        <= 1'b1;
            sh_cnt     <= 0;
            frame      <= '0;
            bits       <= '0;
            last_frame <= '0;
        end else if (iorw == 1'b0 && tbr && !tbr_stuck) begin
            tbr    <= 1'b0;
            frame  <= {1'b1, databus, 1'b0};
            bits   <= '0;
            sh_cnt <= 10;
        end else if (sh_cnt != 0) begin
            frame  <= frame >> 1;
            bits   <= {frame[0], bits[9:1]};
            sh_cnt <= sh_cnt - 1;
            if (sh_cnt == 1) begin
                tbr        <= 1'b1;
                last_frame <= {frame[0], bits[9:1]};
                sent_q.push_back(bits[9:2]);
            end
        end
    end

    // Observation monitor: grants, iorw low-run lengths, high-run before each launch, pulses.
    int grant_q[$];
    int low_q[$];
    int gap_q[$];
    int low_run  = 0;
    int high_run = 0;
    int err_cnt  = 0;
    int rxv_cnt  = 0;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i] === 1'b1) grant_q.push_back(i);
        end
        if (iorw === 1'b0) begin
            if (low_run == 0) gap_q.push_back(high_run);
            low_run  <= low_run + 1;
            high_run <= 0;
        end else begin
            if (low_run != 0) low_q.push_back(low_run);
            low_run  <= 0;
            high_run <= high_run + 1;
        end
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
    end

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        rda   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        grant_q.delete();
        low_q.delete();
        gap_q.delete();
        sent_q.delete();
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({iorw, databus, ack, busy, err, rx_data, rx_valid} !== {1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_async: got iorw=%b db=%h ack=%b busy=%b err=%b rxd=%h rxv=%b, need 1 00 0000 0 0 00 0",
                     iorw, databus, ack, busy, err, rx_data, rx_valid);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total++;
        if ({iorw, busy, ack} !== {1'b1, 1'b0, 4'h0})
            $display("FAIL reset_held: got iorw=%b busy=%b ack=%b, need 1 0 0000", iorw, busy, ack);
        else pass_cnt++;
        // Gap counter starts at GAP, so the first grant after release waits GAP+1 cycles.
        rst_n    = 1'b1;
        req      = 4'b0001;
        req_data = 32'h0000_005A;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != GAP + 1 || ack !== 4'b0001)
            $display("FAIL first_grant_after_reset: got %0d cycles ack=%b, need %0d cycles ack=0001", n, ack, GAP + 1);
        else pass_cnt++;
        req = '0;
        wait_idle(60, ok);
        total++;
        if (!ok) $display("FAIL reset_idle_timeout: busy=%b, need 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_single();
        bit ok;
        int bad;
        repeat (GAP + 1) @(negedge clk);
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) $display("FAIL ack_latency: got %b, need 0001", ack);
        else pass_cnt++;
        req = '0;
        @(negedge clk);
        total++;
        if (iorw !== 1'b0 || databus !== 8'hA5)
            $display("FAIL launch_low: got iorw=%b db=%h, need 0 a5", iorw, databus);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (iorw !== 1'b1) $display("FAIL launch_one_cycle: got iorw=%b, need 1", iorw);
        else pass_cnt++;
        ok  = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && databus !== 8'hA5) bad++;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || bad != 0) $display("FAIL databus_hold: idle=%b bad_cycles=%0d, need 1 0", ok, bad);
        else pass_cnt++;
        total++;
        if (last_frame !== 10'b1_1010_0101_0)
            $display("FAIL frame_a5: got %b, need 1101001010", last_frame);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [19:0] got;
        logic [39:0] bytes;
        int min_gap;
        int max_low;
        apply_reset();
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (grant_q.size() >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        req = '0;
        wait_idle(60, ok);
        got = '1;
        for (int i = 0; i < 5; i++)
            got = {got[15:0], (i < grant_q.size()) ? 4'(grant_q[i]) : 4'hF};
        total++;
        if (got !== 20'h01230) $display("FAIL rr_order: got %h, need 01230", got);
        else pass_cnt++;
        bytes = '1;
        for (int i = 0; i < 5; i++)
            bytes = {bytes[31:0], (i < sent_q.size()) ? sent_q[i] : 8'hFF};
        total++;
        if (bytes !== 40'h10_11_12_13_10 || sent_q.size() != 5)
            $display("FAIL rr_bytes: got %h (%0d frames), need 1011121310 (5)", bytes, sent_q.size());
        else pass_cnt++;
        min_gap = 1000;
        foreach (gap_q[i]) if (gap_q[i] < min_gap) min_gap = gap_q[i];
        max_low = 0;
        foreach (low_q[i]) if (low_q[i] > max_low) max_low = low_q[i];
        total++;
        if (gap_q.size() != 5 || min_gap < GAP || max_low != 1)
            $display("FAIL rr_launches: got %0d launches min_high=%0d max_low=%0d, need 5 >=%0d 1",
                     gap_q.size(), min_gap, max_low, GAP);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        bit ok;
        bit armed;
        logic [11:0] got;
        logic [23:0] bytes;
        apply_reset();
        req      = 4'b0100;
        req_data = 32'h0022_1100;
        armed    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) req[1] = 1'b0;
            if (grant_q.size() >= 1 && !armed) begin
                req[1] = 1'b1;
                armed  = 1'b1;
            end
            if (grant_q.size() >= 3) break;
        end
        req = '0;
        wait_idle(60, ok);
        got = '1;
        for (int i = 0; i < 3; i++)
            got = {got[7:0], (i < grant_q.size()) ? 4'(grant_q[i]) : 4'hF};
        total++;
        if (got !== 12'h212) $display("FAIL fair_order: got %h, need 212", got);
        else pass_cnt++;
        bytes = '1;
        for (int i = 0; i < 3; i++)
            bytes = {bytes[15:0], (i < sent_q.size()) ? sent_q[i] : 8'hFF};
        total++;
        if (bytes !== 24'h22_11_22) $display("FAIL fair_bytes: got %h, need 221122", bytes);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        int err_base;
        repeat (GAP + 1) @(negedge clk);
        tbr_stuck = 1'b1;
        err_base  = err_cnt;
        req       = 4'b0001;
        req_data  = 32'h0000_0055;
        wait_ack(20, ok);
        req = '0;
        @(negedge clk);
        total++;
        if (!ok || iorw !== 1'b0) $display("FAIL tmo_launch: acked=%b iorw=%b, need 1 0", ok, iorw);
        else pass_cnt++;
        k = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                k = i;
                break;
            end
        end
        total++;
        if (k != TIMEOUT) $display("FAIL err_latency: got %0d cycles, need %0d", k, TIMEOUT);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (err !== 1'b0) $display("FAIL err_pulse_width: got err=%b, need 0", err);
        else pass_cnt++;
        wait_idle(10, ok);
        total++;
        if (!ok || err_cnt - err_base != 1)
            $display("FAIL tmo_recover: idle=%b err_pulses=%0d, need 1 1", ok, err_cnt - err_base);
        else pass_cnt++;
        tbr_stuck = 1'b0;
        repeat (GAP + 1) @(negedge clk);
        req      = 4'b1000;
        req_data = 32'h7700_0000;
        wait_ack(20, ok);
        total++;
        if (!ok || ack !== 4'b1000) $display("FAIL post_tmo_ack: got %b, need 1000", ack);
        else pass_cnt++;
        req = '0;
        wait_idle(60, ok);
        total++;
        if (!ok || sent_q.size() == 0 || sent_q[$] !== 8'h77)
            $display("FAIL post_tmo_byte: got %h, need 77", (sent_q.size() != 0) ? sent_q[$] : 8'hXX);
        else pass_cnt++;
    endtask

    task automatic test_rx_overlap();
        bit ok;
        int base;
        repeat (GAP + 1) @(negedge clk);
        req      = 4'b0010;
        req_data = 32'h0000_C300;
        wait_ack(20, ok);
        req = '0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tbr === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        base      = rxv_cnt;
        rx_buffer = 8'h3C;
        rda       = 1'b1;
        @(negedge clk);
        total++;
        if (!ok || rx_valid !== 1'b1 || rx_data !== 8'h3C || busy !== 1'b1)
            $display("FAIL rx_capture: got rxv=%b rxd=%h busy=%b, need 1 3c 1", rx_valid, rx_data, busy);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total++;
        if (rxv_cnt - base != 1 || rx_data !== 8'h3C)
            $display("FAIL rx_single_pulse: got %0d pulses rxd=%h, need 1 3c", rxv_cnt - base, rx_data);
        else pass_cnt++;
        wait_idle(60, ok);
        rda = 1'b0;
        total++;
        if (!ok || last_frame !== {1'b1, 8'hC3, 1'b0})
            $display("FAIL rx_tx_unaffected: got frame %b, need %b", last_frame, {1'b1, 8'hC3, 1'b0});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        repeat (GAP + 1) @(negedge clk);
        req      = 4'b0001;
        req_data = 32'h0000_0099;
        wait_ack(20, ok);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tbr === 1'b0) break;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({iorw, busy, ack} !== {1'b1, 1'b0, 4'h0})
            $display("FAIL reset_mid: got iorw=%b busy=%b ack=%b, need 1 0 0000", iorw, busy, ack);
        else pass_cnt++;
        req      = 4'b1000;
        req_data = 32'hB300_00A0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(20, ok);
        total++;
        if (!ok || ack !== 4'b1000) $display("FAIL ptr_reset_lone3: got %b, need 1000", ack);
        else pass_cnt++;
        req = '0;
        wait_idle(60, ok);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(20, ok);
        total++;
        if (!ok || ack !== 4'b0001) $display("FAIL ptr_reset_prio0: got %b, need 0001", ack);
        else pass_cnt++;
        req[0] = 1'b0;
        wait_ack(60, ok);
        total++;
        if (!ok || ack !== 4'b1000) $display("FAIL ptr_reset_next3: got %b, need 1000", ack);
        else pass_cnt++;
        req = '0;
        wait_idle(60, ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_rx_overlap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
